// File: rtl/dsp_pipe_ctrl_pkg.sv
// Shared encodings for the DSP pipeline hazard controller.
// Opcode macros are only supplied here when the decoder's set is absent.
`ifndef ALU_ADD
`define ALU_NOP    8'h00
`define ALU_ADD    8'h01
`define ALU_SUB    8'h02
`define ALU_MUL    8'h10
`define ALU_MUL_I  8'h11
`define ALU_IMUL   8'h12
`define ALU_IMUL_I 8'h13
`define ALU_MAC    8'h14
`endif
`ifndef MEM_LD
`define MEM_NONE   3'd0
`define MEM_LD     3'd1
`define MEM_ST     3'd2
`endif
`ifndef FLOW_JMP
`define FLOW_NONE  3'd0
`define FLOW_JMP   3'd1
`define FLOW_BEZ   3'd2
`define FLOW_BNEZ  3'd3
`define FLOW_BEQ   3'd4
`endif

package dsp_pipe_ctrl_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MULWAIT = 1'b1
  } ctrl_state_e;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef struct packed {
    logic       v;
    logic [4:0] dest;
    logic       ld;
  } stage_tag_t;

  function automatic logic is_multicycle(
    input logic [7:0] alu_mode
  );
    return alu_mode inside {
      `ALU_MUL, `ALU_MUL_I,
      `ALU_IMUL, `ALU_IMUL_I,
      `ALU_MAC
    };
  endfunction

endpackage

// File: rtl/dsp_fwd_match.sv
// One read port's forwarding source select.
// Youngest matching in-flight producer wins.
module dsp_fwd_match
  import dsp_pipe_ctrl_pkg::*;
(
  input  logic       en,
  input  logic [4:0] src,
  input  stage_tag_t ex,
  input  logic       mem_v,
  input  logic [4:0] mem_dest,
  input  logic       wb_v,
  input  logic [4:0] wb_dest,
  output logic [1:0] sel
);

  logic hit_ex;
  logic hit_mem;
  logic hit_wb;

  assign hit_ex  = ex.v && (ex.dest == src);
  assign hit_mem = mem_v && (mem_dest == src);
  assign hit_wb  = wb_v && (wb_dest == src);

  // A load still in EX has no data yet; the stall covers it.
  always_comb begin
    sel = FWD_RF;
    if (!en)
      sel = FWD_RF;
    else if (hit_ex)
      sel = ex.ld ? FWD_RF : FWD_EX;
    else if (hit_mem)
      sel = FWD_MEM;
    else if (hit_wb)
      sel = FWD_WB;
  end

endmodule

// File: rtl/dsp_pipe_ctrl.sv
// Hazard/sequencing control for the ID-EX-MEM-WB DSP pipe:
// forwarding, load-use stall, multiply hold, branch/jump squash.
module dsp_pipe_ctrl
  import dsp_pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [2:0] id_src_en,
  input  logic [4:0] id_src1,
  input  logic [4:0] id_src2,
  input  logic [4:0] id_src3,
  input  logic       id_dest_en,
  input  logic [4:0] id_dest,
  input  logic [7:0] id_alu_mode,
  input  logic [2:0] id_mem_mode,
  input  logic [2:0] id_flow_mode,
  input  logic       ex_branch_taken,
  output logic       stall_if,
  output logic       stall_id,
  output logic       bubble_ex,
  output logic       flush_if,
  output logic       ex_hold,
  output logic [1:0] fwd_sel1,
  output logic [1:0] fwd_sel2,
  output logic [1:0] fwd_sel3
);

  localparam int CW = $clog2(MUL_LAT + 1);

  ctrl_state_e   state_q;
  ctrl_state_e   state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  stage_tag_t ex_q;
  stage_tag_t mem_q;
  stage_tag_t ex_d;
  logic       wb_v_q;
  logic [4:0] wb_dest_q;

  logic [2:0] port_en;
  logic [2:0] ex_hit;
  logic       ld_use;
  logic       jmp;
  logic       sel_br;
  logic       sel_lu;
  logic       sel_jmp;
  logic       enter_v;
  logic       mul_issue;

  logic       stall_if_c;
  logic       stall_id_c;
  logic       bubble_c;
  logic       flush_c;
  logic       hold_c;
  logic [1:0] sel1_c;
  logic [1:0] sel2_c;
  logic [1:0] sel3_c;

  assign port_en = id_src_en & {3{id_valid}};

  assign ex_hit[0] = port_en[0]
                  && (id_src1 == ex_q.dest);
  assign ex_hit[1] = port_en[1]
                  && (id_src2 == ex_q.dest);
  assign ex_hit[2] = port_en[2]
                  && (id_src3 == ex_q.dest);

  assign ld_use = ex_q.v && ex_q.ld && |ex_hit;
  assign jmp    = id_valid
               && (id_flow_mode == `FLOW_JMP);

  // Mutually exclusive by construction: branch > load-use > jump.
  assign sel_br  = ex_branch_taken;
  assign sel_lu  = ld_use && !ex_branch_taken;
  assign sel_jmp = jmp && !ex_branch_taken && !ld_use;

  always_comb begin
    stall_if_c = 1'b0;
    stall_id_c = 1'b0;
    bubble_c   = 1'b0;
    flush_c    = 1'b0;
    hold_c     = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    mul_issue  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        unique case (1'b1)
          sel_br: begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
          end
          sel_lu: begin
            stall_if_c = 1'b1;
            stall_id_c = 1'b1;
            bubble_c   = 1'b1;
          end
          sel_jmp: flush_c = 1'b1;
          default: ;
        endcase
        mul_issue = id_valid && !bubble_c
                 && is_multicycle(id_alu_mode);
        if (mul_issue && (MUL_LAT > 1)) begin
          state_d = ST_MULWAIT;
          cnt_d   = CW'(MUL_LAT - 1);
        end
      end
      ST_MULWAIT: begin
        hold_c     = 1'b1;
        stall_if_c = 1'b1;
        stall_id_c = 1'b1;
        cnt_d      = cnt_q - CW'(1);
        if (cnt_q == CW'(1))
          state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign enter_v = id_valid && id_dest_en
                && !bubble_c;

  assign ex_d = '{
    v:    enter_v,
    dest: id_dest,
    ld:   enter_v && (id_mem_mode == `MEM_LD)
  };

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      ex_q      <= '0;
      mem_q     <= '0;
      wb_v_q    <= 1'b0;
      wb_dest_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wb_v_q    <= mem_q.v;
      wb_dest_q <= mem_q.dest;
      if (hold_c) begin
        mem_q <= '0;
      end else begin
        mem_q <= ex_q;
        ex_q  <= ex_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      assert (!mem_q.ld || mem_q.v);
  end

  dsp_fwd_match u_fwd1 (
    .en       (port_en[0]),
    .src      (id_src1),
    .ex       (ex_q),
    .mem_v    (mem_q.v),
    .mem_dest (mem_q.dest),
    .wb_v     (wb_v_q),
    .wb_dest  (wb_dest_q),
    .sel      (sel1_c)
  );

  dsp_fwd_match u_fwd2 (
    .en       (port_en[1]),
    .src      (id_src2),
    .ex       (ex_q),
    .mem_v    (mem_q.v),
    .mem_dest (mem_q.dest),
    .wb_v     (wb_v_q),
    .wb_dest  (wb_dest_q),
    .sel      (sel2_c)
  );

  dsp_fwd_match u_fwd3 (
    .en       (port_en[2]),
    .src      (id_src3),
    .ex       (ex_q),
    .mem_v    (mem_q.v),
    .mem_dest (mem_q.dest),
    .wb_v     (wb_v_q),
    .wb_dest  (wb_dest_q),
    .sel      (sel3_c)
  );

  // Everything reads as idle while reset is held.
  assign stall_if  = !reset && stall_if_c;
  assign stall_id  = !reset && stall_id_c;
  assign bubble_ex = !reset && bubble_c;
  assign flush_if  = !reset && flush_c;
  assign ex_hold   = !reset && hold_c;
  assign fwd_sel1  = reset ? FWD_RF : sel1_c;
  assign fwd_sel2  = reset ? FWD_RF : sel2_c;
  assign fwd_sel3  = reset ? FWD_RF : sel3_c;

endmodule
